extend_pipe: RTL and testbench
==============================

# extend_pipe

Multi-lane, mode-selectable width extender with an elastic valid/ready pipeline. It is the parametrised successor of the fixed sign-extend block. Each lane independently zero- or sign-extends either its full input word or the low half of it, which covers load-byte/half/word style extension. The block sits between the memory/immediate path and the execute stage. Unlike its predecessor, it supports backpressure.

## Interface
Parameters:
- LANES, 2, number of independent lanes
- DATA_WIDTH_IN, 16, input width per lane; must be even and ≥ 4
- DATA_WIDTH_OUT, 32, output width per lane; must be > DATA_WIDTH_IN
- STAGES, 1, register stages between input and output; must be ≥ 1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en_n  in  1  active-low global enable; 1 freezes the whole block
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  DATA_WIDTH_IN*LANES  lane k at bits [k*DATA_WIDTH_IN +: DATA_WIDTH_IN]
- in_mode  in  2*LANES  lane k mode at bits [2k +: 2]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH_OUT*LANES  lane k at bits [k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]
- beat_cnt  out  32  accepted-beat counter (see Configuration)

## Operation
- Lane modes, with H = DATA_WIDTH_IN/2:
  - 00: zero-extend the full input.
  - 01: sign-extend the full input from bit DATA_WIDTH_IN-1.
  - 10: zero-extend bits [H-1:0]; upper input bits are ignored.
  - 11: sign-extend bits [H-1:0] from bit H-1.
- Extension is combinational on the input side. The result is captured into stage 0.
- Stages 1..STAGES-1 pass data and valid through unchanged.
- Each stage i holds a data register and v[i]. The stage accepts a new beat when rdy[i] = !v[i] || rdy[i+1], where rdy[STAGES] = out_ready.
- in_ready = !en_n && rdy[0]. out_valid = v[STAGES-1]. out_data = data[STAGES-1].
- A transfer occurs on a cycle where in_valid && in_ready (input side) or out_valid && out_ready && !en_n (output side).
- When en_n = 1:
  - All registers hold and in_ready = 0.
  - out_valid and out_data hold their values.
  - Downstream must not count a transfer while en_n = 1.
- A stage whose downstream moves while it holds no input clears its v[i].
- Simultaneous input accept and output drain in the same cycle is legal and sustains one beat per cycle.
- Reset:
  - All v[i] = 0, all data registers = 0, beat_cnt = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1 in the first cycle after reset, provided en_n = 0.
- Reset mid-operation discards all in-flight beats; none are emitted.

## Timing
- Latency is STAGES cycles from an input transfer to out_valid, with no stalls.
- Throughput is 1 beat/cycle while out_ready = 1 and en_n = 0.
- in_ready depends combinationally on out_ready (ready chain through all stages). There is no combinational path from in_data to out_data.
- Capacity is STAGES beats. With out_ready = 0, in_ready falls once all stages are full.

## Configuration
- EXTEND_PIPE_CNT_EN defined:
  - beat_cnt increments by 1 on every input transfer and wraps modulo 2^32.
  - Reset clears it. en_n = 1 holds it.
- EXTEND_PIPE_CNT_EN undefined:
  - The counter logic is not compiled.
  - beat_cnt is tied to 0.

## Structure
- Package extend_pkg holds:
  - mode constants EXT_ZERO_FULL = 2'b00, EXT_SIGN_FULL = 2'b01, EXT_ZERO_HALF = 2'b10, EXT_SIGN_HALF = 2'b11;
  - a typedef for the 2-bit mode.
- Sub-module extend_lane is a combinational single-lane extender (data, mode → extended word), instantiated LANES times in a generate loop.
- Pipeline stages are generated inside extend_pipe. No separate stage module.

## Test plan
- Defaults, STAGES=1, in_data=16'h8001/16'h00F0, modes 01/00, out_ready=1:
  - one cycle later, out_data lane0 = 32'hFFFF8001 and lane1 = 32'h000000F0.
- Half modes, in_data lane0=16'hAB80 mode 11, lane1=16'hAB80 mode 10:
  - lane0 = 32'hFFFFFF80, lane1 = 32'h00000080.
- STAGES=3, out_ready=0, stream 5 beats:
  - in_ready drops after the 3rd accept.
  - Release out_ready: beats emerge in order, no loss or duplication.
  - Then back-to-back throughput is 1/cycle.
- en_n=1 for 4 cycles with a beat at the output and out_ready=1:
  - out_valid and out_data hold, in_ready=0, and nothing advances.
  - The beat is consumed on the first cycle with en_n=0.
- Assert rst with 2 beats in flight:
  - next cycle out_valid=0, out_data=0, beat_cnt=0.
  - No stale beat appears afterwards.
- With EXTEND_PIPE_CNT_EN, 7 accepted beats with 3 refused cycles interleaved → beat_cnt=7.
- Without EXTEND_PIPE_CNT_EN, beat_cnt stays 0.

Source files
------------

// File: rtl/extend_pipe_pkg.sv
// Shared types for the extend_pipe slice: per-lane extension mode encoding.
package extend_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO_FULL = 2'b00,
    EXT_SIGN_FULL = 2'b01,
    EXT_ZERO_HALF = 2'b10,
    EXT_SIGN_HALF = 2'b11
  } ext_mode_t;

endpackage

// File: rtl/extend_pipe_if.sv
// Upstream/downstream valid-ready bus of extend_pipe; slave is the block's view.
interface extend_pipe_if #(
  parameter int unsigned LANES          = 2,
  parameter int unsigned DATA_WIDTH_IN  = 16,
  parameter int unsigned DATA_WIDTH_OUT = 32
);
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH_IN*LANES-1:0]  in_data;
  logic [2*LANES-1:0]              in_mode;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH_OUT*LANES-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/extend_pipe_lane.sv
// Combinational single-lane extender: zero/sign extension of the full word or its low half.
module extend_lane
  import extend_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN  = 16,
  parameter int unsigned DATA_WIDTH_OUT = 32
) (
  input  logic [DATA_WIDTH_IN-1:0]  data_i,
  input  ext_mode_t                 mode_i,
  output logic [DATA_WIDTH_OUT-1:0] data_o
);
  localparam int unsigned H = DATA_WIDTH_IN / 2;

  always_comb begin
    data_o = '0;
    case (mode_i)
      EXT_ZERO_FULL: data_o = {{(DATA_WIDTH_OUT-DATA_WIDTH_IN){1'b0}}, data_i};
      EXT_SIGN_FULL: data_o = {{(DATA_WIDTH_OUT-DATA_WIDTH_IN){data_i[DATA_WIDTH_IN-1]}}, data_i};
      EXT_ZERO_HALF: data_o = {{(DATA_WIDTH_OUT-H){1'b0}}, data_i[H-1:0]};
      EXT_SIGN_HALF: data_o = {{(DATA_WIDTH_OUT-H){data_i[H-1]}}, data_i[H-1:0]};
      default:       data_o = '0;
    endcase
  end
endmodule

// File: rtl/extend_pipe.sv
// Multi-lane width extender with an elastic STAGES-deep valid/ready pipeline.
// Optional accepted-beat counter enabled by defining EXTEND_PIPE_CNT_EN.
module extend_pipe
  import extend_pkg::*;
#(
  parameter int unsigned LANES          = 2,
  parameter int unsigned DATA_WIDTH_IN  = 16,
  parameter int unsigned DATA_WIDTH_OUT = 32,
  parameter int unsigned STAGES         = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_n,
  extend_pipe_if.slave  bus,
  output logic [31:0]   beat_cnt
);
  localparam int unsigned W = DATA_WIDTH_OUT * LANES;

  logic [W-1:0]      ext_data;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] rdy;
  logic              in_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    extend_lane #(
      .DATA_WIDTH_IN (DATA_WIDTH_IN),
      .DATA_WIDTH_OUT(DATA_WIDTH_OUT)
    ) u_lane (
      .data_i(bus.in_data[k*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
      .mode_i(ext_mode_t'(bus.in_mode[2*k +: 2])),
      .data_o(ext_data[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT])
    );
  end

  // Ready chain unrolled: stage i can move if out_ready or any stage from i onward is empty.
  always_comb begin
    rdy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[i] = bus.out_ready;
      for (int unsigned j = i; j < STAGES; j++) begin
        if (!v_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign in_ready = !en_n && rdy[0];

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (!en_n) begin
      if (rdy[0]) begin
        v_d[0] = bus.in_valid;
        if (bus.in_valid) data_d[0] = ext_data;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      data_q <= '{default: '0};
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];

`ifdef EXTEND_PIPE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && in_ready) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif
endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench for extend_pipe: one default (STAGES=1) and one STAGES=3 instance.
module tb_extend_pipe;
  logic        clk;
  logic        rst;
  logic        en_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_mode;
  logic        out_ready;
  logic [31:0] beat_cnt1, beat_cnt3;

  int tests = 0;
  int fails = 0;
  int acc1  = 0;
  int acc3  = 0;
  logic [63:0] q1[$];
  logic [63:0] q3[$];

`ifdef EXTEND_PIPE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  extend_pipe_if #(.LANES(2), .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(32)) bus1 ();
  extend_pipe_if #(.LANES(2), .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(32)) bus3 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.in_mode   = in_mode;
  assign bus1.out_ready = out_ready;
  assign bus3.in_valid  = in_valid;
  assign bus3.in_data   = in_data;
  assign bus3.in_mode   = in_mode;
  assign bus3.out_ready = out_ready;

  extend_pipe #(.LANES(2), .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(32), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .en_n(en_n), .bus(bus1.slave), .beat_cnt(beat_cnt1)
  );
  extend_pipe #(.LANES(2), .DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(32), .STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .en_n(en_n), .bus(bus3.slave), .beat_cnt(beat_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] d, input logic [3:0] m);
    logic [63:0]        r;
    logic [15:0]        w;
    logic [7:0]         lo;
    logic signed [31:0] s;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      w  = d[k*16 +: 16];
      lo = w[7:0];
      case (m[2*k +: 2])
        2'b00:   s = $signed({16'h0000, w});
        2'b01:   s = $signed(w);
        2'b10:   s = $signed({24'h000000, lo});
        default: s = $signed(lo);
      endcase
      r[k*32 +: 32] = s;
    end
    return r;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle commit at the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q3.delete();
      acc1 = 0;
      acc3 = 0;
    end else begin
      if (bus1.out_valid && out_ready && !en_n) begin
        if (q1.size() == 0) chk("sb1_extra", {63'd0, bus1.out_valid}, 64'd0);
        else                chk("sb1_data", bus1.out_data, q1.pop_front());
      end
      if (bus3.out_valid && out_ready && !en_n) begin
        if (q3.size() == 0) chk("sb3_extra", {63'd0, bus3.out_valid}, 64'd0);
        else                chk("sb3_data", bus3.out_data, q3.pop_front());
      end
      if (in_valid && bus1.in_ready) begin
        q1.push_back(model(in_data, in_mode));
        acc1++;
      end
      if (in_valid && bus3.in_ready) begin
        q3.push_back(model(in_data, in_mode));
        acc3++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_beat();
    in_valid = 1'b1;
    in_data  = $urandom;
    in_mode  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic [63:0] held;
    int          got5;
    int          guard;
    bit          allrdy, allout, stale;

    rst = 1'b1; en_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ov1",  {63'd0, bus1.out_valid}, 64'd0);
    chk("rst_od1",  bus1.out_data, 64'd0);
    chk("rst_cnt1", {32'd0, beat_cnt1}, 64'd0);
    chk("rst_ir1",  {63'd0, bus1.in_ready}, 64'd1);
    chk("rst_ir3",  {63'd0, bus3.in_ready}, 64'd1);
    chk("rst_ov3",  {63'd0, bus3.out_valid}, 64'd0);

    // Full-width modes, then latency of the 3-stage instance
    step();
    in_valid = 1'b1; in_data = {16'h00F0, 16'h8001}; in_mode = 4'b0001;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_ov1", {63'd0, bus1.out_valid}, 64'd1);
    chk("full_od1", bus1.out_data, 64'h000000F0_FFFF8001);
    chk("lat3_early", {63'd0, bus3.out_valid}, 64'd0);
    step();
    step();
    @(negedge clk);
    chk("lat3_ov", {63'd0, bus3.out_valid}, 64'd1);
    chk("lat3_od", bus3.out_data, 64'h000000F0_FFFF8001);

    // Half-width modes
    step();
    in_valid = 1'b1; in_data = {16'hAB80, 16'hAB80}; in_mode = 4'b1011;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("half_od1", bus1.out_data, 64'h00000080_FFFFFF80);
    repeat (5) step();

    // Backpressure: 3-stage instance fills after three accepts
    out_ready = 1'b0;
    got5 = 0;
    for (int c = 0; c < 5; c++) begin
      rnd_beat();
      @(negedge clk);
      chk("bp_ir3", {63'd0, bus3.in_ready}, (c < 3) ? 64'd1 : 64'd0);
      if (bus3.in_ready) got5++;
      step();
    end
    out_ready = 1'b1;
    guard = 0;
    while (got5 < 5 && guard < 10) begin
      rnd_beat();
      @(negedge clk);
      if (bus3.in_ready) got5++;
      guard++;
      step();
    end
    chk("bp_accepts", 64'(got5), 64'd5);
    in_valid = 1'b0;
    repeat (6) step();

    // Back-to-back throughput
    allrdy = 1'b1; allout = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rnd_beat();
      @(negedge clk);
      if (!bus3.in_ready) allrdy = 1'b0;
      if (c >= 3 && !bus3.out_valid) allout = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("thru_ir3", {63'd0, allrdy}, 64'd1);
    chk("thru_ov3", {63'd0, allout}, 64'd1);
    repeat (6) step();

    // Global enable freeze with a beat waiting at the output
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234F00D; in_mode = 4'b0110;
    held = model(32'h1234F00D, 4'b0110);
    step();
    en_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = $urandom;
      @(negedge clk);
      chk("frz_ov1", {63'd0, bus1.out_valid}, 64'd1);
      chk("frz_od1", bus1.out_data, held);
      chk("frz_ir1", {63'd0, bus1.in_ready}, 64'd0);
      step();
    end
    en_n = 1'b0; in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("frz_consumed", {63'd0, bus1.out_valid}, 64'd0);
    repeat (6) step();

    // Reset with beats in flight
    out_ready = 1'b0;
    rnd_beat();
    step();
    rnd_beat();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ov3",  {63'd0, bus3.out_valid}, 64'd0);
    chk("mrst_od3",  bus3.out_data, 64'd0);
    chk("mrst_cnt3", {32'd0, beat_cnt3}, 64'd0);
    chk("mrst_ov1",  {63'd0, bus1.out_valid}, 64'd0);
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus1.out_valid || bus3.out_valid) stale = 1'b1;
      step();
    end
    chk("no_stale", {63'd0, stale}, 64'd0);

    // Beat counter: 7 accepts with 3 refused cycles interleaved
    for (int c = 0; c < 10; c++) begin
      en_n = (c == 2 || c == 5 || c == 8);
      rnd_beat();
      step();
    end
    en_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("cnt7_dut1",  {32'd0, beat_cnt1}, CNT_ON ? 64'd7 : 64'd0);
    chk("cnt7_dut3",  {32'd0, beat_cnt3}, CNT_ON ? 64'd7 : 64'd0);
    chk("cnt_model1", {32'd0, beat_cnt1}, CNT_ON ? 64'(acc1) : 64'd0);
    repeat (6) step();

    @(negedge clk);
    chk("sb1_empty", 64'(q1.size()), 64'd0);
    chk("sb3_empty", 64'(q3.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
